// File: rtl/csr_access_arbiter.sv
// csr_access_arbiter
// Shares a CSR file between NUM_REQ requesters. Each granted access runs
// read -> optional modify-write -> one-cycle response. Round-robin grant.
module csr_access_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_REQ*2-1:0]        req_op_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]          rsp_valid_o,
    output logic [DATA_W-1:0]           rsp_rdata_o,
    output logic                        rsp_err_o,
    output logic                        csr_access_o,
    output logic [ADDR_W-1:0]           csr_addr_o,
    input  logic [DATA_W-1:0]           csr_rdata_i,
    input  logic                        csr_illegal_i,
    output logic                        csr_we_o,
    output logic [DATA_W-1:0]           csr_wdata_o
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Read-modify-write combine of the old CSR value with the request data.
    function automatic logic [DATA_W-1:0] apply_op(
        input logic [1:0]        op,
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] mask
    );
        logic [DATA_W-1:0] res;
        case (op)
            OP_WRITE: res = mask;
            OP_SET:   res = old_val | mask;
            OP_CLEAR: res = old_val & ~mask;
            default:  res = old_val;
        endcase
        return res;
    endfunction

    state_t              state_r;
    state_t              next_s;
    logic [GW-1:0]       last_grant_r;
    logic [GW-1:0]       id_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [1:0]          op_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W-1:0]   old_r;
    logic                err_r;

    logic                access_r;
    logic [ADDR_W-1:0]   caddr_r;
    logic                we_r;
    logic [DATA_W-1:0]   cwdata_r;
    logic [NUM_REQ-1:0]  rsp_valid_r;
    logic [DATA_W-1:0]   rsp_rdata_r;
    logic                rsp_err_r;

    logic                grant_found_s;
    logic [GW-1:0]       grant_idx_s;
    logic [GW-1:0]       cand_s;
    logic                hit_s;
    logic [NUM_REQ-1:0]  ready_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [1:0]          sel_op_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic [DATA_W-1:0]   rd_val_s;
    logic                err_s;
    logic [DATA_W-1:0]   mod_val_s;

    // Round-robin search: first valid requester after the last grant.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        hit_s         = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s        = GW'((int'(last_grant_r) + k) % NUM_REQ);
            hit_s         = !grant_found_s && req_valid_i[cand_s];
            grant_idx_s   = hit_s ? cand_s : grant_idx_s;
            grant_found_s = grant_found_s | hit_s;
        end
    end

    // Accept strobe and the granted requester's fields.
    always_comb begin
        ready_s     = '0;
        sel_addr_s  = req_addr_i[grant_idx_s*ADDR_W +: ADDR_W];
        sel_op_s    = req_op_i[grant_idx_s*2 +: 2];
        sel_wdata_s = req_wdata_i[grant_idx_s*DATA_W +: DATA_W];
        if ((state_r == ST_IDLE) && grant_found_s && !rst) begin
            ready_s = ONE_HOT0 << grant_idx_s;
        end else begin
            ready_s = '0;
        end
    end

    // Read-phase evaluation: an unimplemented CSR reads back as zero.
    always_comb begin
        rd_val_s  = csr_illegal_i ? '0 : csr_rdata_i;
        err_s     = csr_illegal_i |
                    ((op_r != OP_NONE) && (addr_r[ADDR_W-1 -: 2] == 2'b11));
        mod_val_s = apply_op(op_r, rd_val_s, wdata_r);
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (|ready_s) begin
                    next_s = ST_READ;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (err_s || (op_r == OP_NONE)) begin
                    next_s = ST_RESP;
                end else begin
                    next_s = ST_WRITE;
                end
            end
            ST_WRITE: next_s = ST_RESP;
            ST_RESP:  next_s = ST_IDLE;
            default:  next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Capture of the granted request and the round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= GW'(NUM_REQ - 1);
            id_r         <= '0;
            addr_r       <= '0;
            op_r         <= OP_NONE;
            wdata_r      <= '0;
        end else if (|ready_s) begin
            last_grant_r <= grant_idx_s;
            id_r         <= grant_idx_s;
            addr_r       <= sel_addr_s;
            op_r         <= sel_op_s;
            wdata_r      <= sel_wdata_s;
        end
    end

    // Old value and error status latched during the read cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            old_r <= '0;
            err_r <= 1'b0;
        end else if (state_r == ST_READ) begin
            old_r <= rd_val_s;
            err_r <= err_s;
        end
    end

    // Registered CSR-file strobes, set up for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            access_r <= 1'b0;
            caddr_r  <= '0;
            we_r     <= 1'b0;
            cwdata_r <= '0;
        end else begin
            access_r <= (next_s == ST_READ);
            if (next_s == ST_READ) begin
                caddr_r <= sel_addr_s;
            end else if (next_s == ST_WRITE) begin
                caddr_r <= addr_r;
            end else begin
                caddr_r <= '0;
            end
            we_r     <= (next_s == ST_WRITE);
            cwdata_r <= (next_s == ST_WRITE) ? mod_val_s : '0;
        end
    end

    // Response pulse to the owner; data and error hold until the next response.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= '0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
        end else if (next_s == ST_RESP) begin
            rsp_valid_r <= ONE_HOT0 << id_r;
            rsp_rdata_r <= (state_r == ST_READ) ? rd_val_s : old_r;
            rsp_err_r   <= (state_r == ST_READ) ? err_s : err_r;
        end else begin
            rsp_valid_r <= '0;
        end
    end

    assign req_ready_o  = ready_s;
    assign rsp_valid_o  = rsp_valid_r;
    assign rsp_rdata_o  = rsp_rdata_r;
    assign rsp_err_o    = rsp_err_r;
    assign csr_access_o = access_r;
    assign csr_addr_o   = caddr_r;
    assign csr_we_o     = we_r;
    assign csr_wdata_o  = cwdata_r;

endmodule
